// File: rtl/track_sched_pkg.sv
// Shared types, constants and the saturation helper for the track playback scheduler.
// Latency: none. This file holds only types, constants and a pure function.
// Backpressure: none. Nothing here carries state.
package track_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_READ    = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Gain is unsigned Q1.7, so 128 is unity.
  localparam int GAIN_FRAC  = 7;
  localparam int GAIN_UNITY = 128;

  // Clamp v to the signed range of a w-bit number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/track_playback_scheduler_if.sv
// FIFO-bank bus between the scheduler and the NUM_TRACKS track FIFOs.
// Latency: none. fifo_wr and fifo_rd are edge-triggered at the FIFO, and fifo_dout is the head of each FIFO.
// Backpressure: none on the bus. Write gating against occupancy happens in the scheduler.
//   master (scheduler): drives fifo_wr and fifo_rd, receives fifo_dout (track 0 in the LSBs)
//   slave  (FIFO bank): receives fifo_wr and fifo_rd, drives fifo_dout
interface track_playback_scheduler_if #(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 16
);
  logic [NUM_TRACKS-1:0]       fifo_wr;
  logic [NUM_TRACKS-1:0]       fifo_rd;
  logic [NUM_TRACKS*WIDTH-1:0] fifo_dout;

  modport master (output fifo_wr, output fifo_rd, input fifo_dout);
  modport slave  (input fifo_wr, input fifo_rd, output fifo_dout);
endinterface

// File: rtl/track_playback_scheduler_level_counter.sv
// Per-track occupancy tracker. It gates writes against full and keeps the level, the read-safe avail count and the overflow flag.
// Latency: fifo_wr_o is combinational from wr_req_i. level_o updates 1 cycle after an event. avail_o sees increments 2 cycles after level_o.
// Backpressure: a write to a full track is dropped (fifo_wr_o stays low) and sets the sticky overflow_o.
//   in : clk, rst, wr_req_i, rd_i (read-advance pulse), clear_flags_i
//   out: fifo_wr_o, level_o, avail_o, full_o, empty_o, overflow_o
module track_level_counter #(
  parameter  int DEPTH = 512,
  localparam int LW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req_i,
  input  logic          rd_i,
  input  logic          clear_flags_i,
  output logic          fifo_wr_o,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] avail_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o
);
  import track_sched_pkg::*;

  logic          wr_prev_q, wr_prev_d;
  logic [1:0]    inc_dly_q, inc_dly_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] avail_q, avail_d;
  logic          overflow_q, overflow_d;
  logic          wr_edge;

  assign full_o    = (level_q == LW'(DEPTH - 1));
  assign empty_o   = (level_q == '0);
  assign fifo_wr_o = wr_req_i & ~full_o;
  // The FIFO captures on the rising edge of its wr, so a held request is one sample.
  assign wr_edge   = fifo_wr_o & ~wr_prev_q;

  always_comb begin
    wr_prev_d  = fifo_wr_o;
    inc_dly_d  = {inc_dly_q[0], wr_edge};
    level_d    = level_q + LW'(wr_edge) - LW'(rd_i);
    // avail counts a write only after the FIFO head has had time to show it,
    // but counts reads at once so the scheduler never double-reads.
    avail_d    = avail_q + LW'(inc_dly_q[1]) - LW'(rd_i);
    overflow_d = (overflow_q & ~clear_flags_i) | (wr_req_i & full_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prev_q  <= 1'b0;
      inc_dly_q  <= '0;
      level_q    <= '0;
      avail_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_prev_q  <= wr_prev_d;
      inc_dly_q  <= inc_dly_d;
      level_q    <= level_d;
      avail_q    <= avail_d;
      overflow_q <= overflow_d;
    end
  end

  assign level_o    = level_q;
  assign avail_o    = avail_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/track_playback_scheduler.sv
// Track FIFO access controller and per-tick mixer. It walks the tracks on each sample_tick, reads their heads, applies gain and mute, and emits a saturated sum.
// Latency: mix_valid is high 2+3*NUM_TRACKS cycles after sample_tick. fifo_wr is combinational from wr_req.
// Backpressure: none downstream. A tick that arrives while busy is dropped and sets tick_missed. Writes to a full track are dropped and set overflow.
//   in : clk, rst, sample_tick, wr_req, gain, mute, clear_flags, fifo_bus.fifo_dout
//   out: fifo_bus.fifo_wr/fifo_rd, level, full, empty, underrun, overflow, tick_missed, mix_out, mix_valid, busy
module track_playback_scheduler
  import track_sched_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 512,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_tick,
  input  logic [NUM_TRACKS-1:0]               wr_req,
  track_playback_scheduler_if.master          fifo_bus,
  input  logic [NUM_TRACKS*GAIN_WIDTH-1:0]    gain,
  input  logic [NUM_TRACKS-1:0]               mute,
  input  logic                                clear_flags,
  output logic [NUM_TRACKS*$clog2(DEPTH)-1:0] level,
  output logic [NUM_TRACKS-1:0]               full,
  output logic [NUM_TRACKS-1:0]               empty,
  output logic [NUM_TRACKS-1:0]               underrun,
  output logic [NUM_TRACKS-1:0]               overflow,
  output logic                                tick_missed,
  output logic signed [WIDTH-1:0]             mix_out,
  output logic                                mix_valid,
  output logic                                busy
);

  localparam int LW = $clog2(DEPTH);
  localparam int IW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
  localparam int PW = WIDTH + GAIN_WIDTH + 1;
  localparam int AW = WIDTH + GAIN_WIDTH + $clog2(NUM_TRACKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TRACKS - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]    contrib_q, contrib_d;
  logic                    present_q, present_d;
  logic [NUM_TRACKS-1:0]   underrun_q, underrun_d;
  logic                    tick_missed_q, tick_missed_d;
  logic signed [WIDTH-1:0] mix_out_q, mix_out_d;
  logic                    mix_valid_q, mix_valid_d;

  logic [NUM_TRACKS-1:0]   wr_vec;
  logic [NUM_TRACKS-1:0]   rd_vec;
  logic [LW-1:0]           avail [NUM_TRACKS];

  logic [WIDTH-1:0]        sample;
  logic [GAIN_WIDTH-1:0]   gain_cur;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    scaled;

  for (genvar k = 0; k < NUM_TRACKS; k++) begin : g_trk
    track_level_counter #(.DEPTH(DEPTH)) u_cnt (
      .clk           (clk),
      .rst           (rst),
      .wr_req_i      (wr_req[k]),
      .rd_i          (rd_vec[k]),
      .clear_flags_i (clear_flags),
      .fifo_wr_o     (wr_vec[k]),
      .level_o       (level[k*LW +: LW]),
      .avail_o       (avail[k]),
      .full_o        (full[k]),
      .empty_o       (empty[k]),
      .overflow_o    (overflow[k])
    );
  end

  assign fifo_bus.fifo_wr = wr_vec;
  assign fifo_bus.fifo_rd = rd_vec;

  // Gain is unsigned, so zero-extend it before the signed multiply.
  assign sample   = fifo_bus.fifo_dout[idx_q*WIDTH +: WIDTH];
  assign gain_cur = gain[idx_q*GAIN_WIDTH +: GAIN_WIDTH];
  assign prod     = $signed({{(PW-WIDTH){sample[WIDTH-1]}}, sample}) *
                    $signed({{(PW-GAIN_WIDTH){1'b0}}, gain_cur});
  assign scaled   = prod >>> GAIN_FRAC;

  // The read pulse comes from registered state, so it is one clean cycle per track.
  always_comb begin
    rd_vec = '0;
    if (state_q == ST_READ && present_q) rd_vec[idx_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    contrib_d     = contrib_q;
    present_d     = present_q;
    underrun_d    = underrun_q & ~{NUM_TRACKS{clear_flags}};
    tick_missed_d = tick_missed_q & ~clear_flags;
    mix_out_d     = mix_out_q;
    mix_valid_d   = 1'b0;

    if (sample_tick && state_q != ST_IDLE) tick_missed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_CAPTURE;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      // Capture the scaled head sample rather than the raw sample. Gain and mute are
      // only looked at here.
      ST_CAPTURE: begin
        present_d = (avail[idx_q] != '0);
        if (!present_d) begin
          contrib_d           = '0;
          underrun_d[idx_q]   = 1'b1;
        end else if (mute[idx_q]) begin
          contrib_d = '0;
        end else begin
          contrib_d = scaled;
        end
        state_d = ST_READ;
      end
      ST_READ: begin
        acc_d   = acc_q + AW'(contrib_q);
        state_d = ST_GAP;
      end
      // GAP exists so that fifo_rd drops low between consecutive reads.
      ST_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        mix_out_d   = WIDTH'(saturate(64'(acc_q), WIDTH));
        mix_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      contrib_q     <= '0;
      present_q     <= 1'b0;
      underrun_q    <= '0;
      tick_missed_q <= 1'b0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      contrib_q     <= contrib_d;
      present_q     <= present_d;
      underrun_q    <= underrun_d;
      tick_missed_q <= tick_missed_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
    end
  end

  assign underrun    = underrun_q;
  assign tick_missed = tick_missed_q;
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_track_playback_scheduler.sv
// Bench for track_playback_scheduler. It includes a behavioural FIFO bank and a queue-based mix model.
// Latency: each expected mix is checked at tick + 2 + 3*NUM_TRACKS cycles.
// Backpressure: none. Stimulus waits fixed cycle budgets between ticks.
module tb_track_playback_scheduler;
  import track_sched_pkg::*;

  localparam int NT  = 4;
  localparam int W   = 16;
  localparam int D   = 512;
  localparam int GW  = 8;
  localparam int LW  = 9;
  localparam int LAT = 2 + 3 * NT;

  logic              clk = 1'b0;
  logic              rst, sample_tick, clear_flags;
  logic [NT-1:0]     wr_req, mute, full, empty, underrun, overflow;
  logic [NT*GW-1:0]  gain;
  logic [NT*LW-1:0]  level;
  logic              tick_missed, mix_valid, busy;
  logic signed [W-1:0] mix_out;
  logic [W-1:0]      din [NT];

  track_playback_scheduler_if #(.NUM_TRACKS(NT), .WIDTH(W)) bus ();

  track_playback_scheduler #(.NUM_TRACKS(NT), .WIDTH(W), .DEPTH(D), .GAIN_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .wr_req(wr_req), .fifo_bus(bus),
    .gain(gain), .mute(mute), .clear_flags(clear_flags), .level(level), .full(full),
    .empty(empty), .underrun(underrun), .overflow(overflow), .tick_missed(tick_missed),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO bank model. It pushes and pops on the rising edges of wr and rd.
  logic [W-1:0]  mem [NT][D];
  int            wp [NT];
  int            rp [NT];
  logic [NT-1:0] fwr_prev = '0;
  logic [NT-1:0] frd_prev = '0;

  always @(negedge clk) begin
    for (int k = 0; k < NT; k++) begin
      if (rst) begin
        wp[k] = 0;
        rp[k] = 0;
      end else begin
        if (bus.fifo_wr[k] && !fwr_prev[k]) begin
          mem[k][wp[k] % D] = din[k];
          wp[k]++;
        end
        if (bus.fifo_rd[k] && !frd_prev[k] && rp[k] != wp[k]) rp[k]++;
      end
      bus.fifo_dout[k*W +: W] = mem[k][rp[k] % D];
    end
    fwr_prev = rst ? '0 : bus.fifo_wr;
    frd_prev = rst ? '0 : bus.fifo_rd;
  end

  // Scoreboard
  typedef struct {
    int val;
    int cyc;
  } exp_t;
  exp_t          exp_q [$];
  exp_t          e_m;
  int            mv_cnt = 0;
  int            rd_cnt [NT] = '{default: 0};
  logic [NT-1:0] rd_prev_mon = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mix_valid) begin
        mv_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected mix_valid", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          chk("mix_out", longint'(mix_out), e_m.val);
          chk("mix latency", cyc, e_m.cyc);
        end
      end
      for (int k = 0; k < NT; k++) begin
        if (bus.fifo_rd[k]) begin
          rd_cnt[k]++;
          chk("fifo_rd single-cycle", rd_prev_mon[k], 0);
        end
      end
    end
    rd_prev_mon = rst ? '0 : bus.fifo_rd;
  end

  // Reference model: a sample queue per track, mixed at tick level.
  int mdata [NT][1024];
  int mhead [NT];
  int mtail [NT];

  function automatic void mflush();
    for (int k = 0; k < NT; k++) begin
      mhead[k] = 0;
      mtail[k] = 0;
    end
  endfunction

  function automatic void mpush(input int k, input int v);
    if (mtail[k] - mhead[k] < D - 1) begin
      mdata[k][mtail[k] % 1024] = v;
      mtail[k]++;
    end
  endfunction

  function automatic int model_mix(input logic [NT-1:0] mt, input logic [NT*GW-1:0] g);
    int acc = 0;
    int s;
    int gk;
    for (int k = 0; k < NT; k++) begin
      if (mtail[k] != mhead[k]) begin
        s = mdata[k][mhead[k] % 1024];
        mhead[k]++;
        gk = int'(g[k*GW +: GW]);
        if (!mt[k]) acc += (s * gk) >>> GAIN_FRAC;
      end
    end
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input int v);
    @(posedge clk); #1;
    din[k]    = 16'(v);
    wr_req[k] = 1'b1;
    @(posedge clk); #1;
    wr_req[k] = 1'b0;
    mpush(k, v);
  endtask

  task automatic tick(input int expv, input bit expect_out);
    @(posedge clk); #1;
    if (expect_out) exp_q.push_back('{expv, cyc + LAT});
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " level"}, level, 0);
    chk({tag, " empty"}, empty, 4'hF);
    chk({tag, " full"}, full, 0);
    chk({tag, " underrun"}, underrun, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " tick_missed"}, tick_missed, 0);
    chk({tag, " fifo_rd"}, bus.fifo_rd, 0);
    chk({tag, " mix_out"}, mix_out, 0);
    chk({tag, " mix_valid"}, mix_valid, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rd0, rd1, mvs, ev, n;
    rst = 1'b1; sample_tick = 1'b0; clear_flags = 1'b0; wr_req = '0; mute = '0;
    gain = {NT{8'(GAIN_UNITY)}};
    for (int k = 0; k < NT; k++) din[k] = '0;
    mflush();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("por");

    // Three samples on track 0 at unity gain, played out one per tick
    rd0 = rd_cnt[0]; rd1 = rd_cnt[1];
    wr(0, 1000); wr(0, -2000); wr(0, 300);
    idle(3);
    tick(1000, 1);  idle(16);
    tick(-2000, 1); idle(16);
    tick(300, 1);   idle(16);
    chk("trk0 rd pulses", rd_cnt[0] - rd0, 3);
    chk("trk1 rd pulses", rd_cnt[1] - rd1, 0);
    chk("trk0 level drained", level[0 +: LW], 0);
    chk("trk1 underrun", underrun[1], 1);
    pulse_clear();
    chk("underrun cleared", underrun[1], 0);

    // Saturation at both rails
    gain = {NT{8'd255}};
    for (int k = 0; k < NT; k++) wr(k, 32767);
    idle(3);
    tick(32767, 1); idle(16);
    for (int k = 0; k < NT; k++) wr(k, -32768);
    idle(3);
    tick(-32768, 1); idle(16);
    gain = {NT{8'(GAIN_UNITY)}};
    pulse_clear();

    // A write to track 3 one cycle before its capture is too late for this tick
    tick(0, 1);
    repeat (8) @(posedge clk);
    #1 din[3] = 16'd555; wr_req[3] = 1'b1;
    @(posedge clk); #1 wr_req[3] = 1'b0;
    idle(10);
    chk("late write underrun trk3", underrun[3], 1);
    tick(555, 1); idle(16);
    chk("trk3 level drained", level[3*LW +: LW], 0);
    pulse_clear();

    // A second tick while busy is dropped
    gain = {NT{8'd64}};
    wr(1, 7);
    idle(3);
    mvs = mv_cnt;
    tick(3, 1);
    repeat (4) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    idle(20);
    chk("tick_missed", tick_missed, 1);
    chk("one mix per accepted tick", mv_cnt - mvs, 1);
    pulse_clear();
    chk("tick_missed cleared", tick_missed, 0);

    // Randomised writes, gains and mutes against the model
    chk("levels empty before random", level, 0);
    mflush();
    for (int it = 0; it < 40; it++) begin
      mute = 4'($urandom_range(0, 15));
      gain = $urandom;
      for (int k = 0; k < NT; k++) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) wr(k, int'($urandom_range(0, 65535)) - 32768);
      end
      idle(3);
      ev = model_mix(mute, gain);
      tick(ev, 1);
      idle(16);
      for (int k = 0; k < NT; k++) chk("random level", level[k*LW +: LW], mtail[k] - mhead[k]);
    end

    // Fill track 2 to DEPTH-1, then try one more write
    pulse_clear();
    for (int i = 0; i < D - 1; i++) wr(2, i);
    idle(3);
    chk("trk2 level at full", level[2*LW +: LW], D - 1);
    chk("trk2 full", full[2], 1);
    din[2] = 16'h1234; wr_req[2] = 1'b1;
    @(negedge clk);
    chk("fifo_wr gated when full", bus.fifo_wr[2], 0);
    @(posedge clk); #1 wr_req[2] = 1'b0;
    idle(2);
    chk("trk2 overflow", overflow[2], 1);
    chk("trk2 level holds", level[2*LW +: LW], D - 1);

    // Reset in the middle of a sequence
    wr(0, 42);
    idle(3);
    mvs = mv_cnt;
    tick(0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset("mid");
    idle(20);
    chk("no mix after mid reset", mv_cnt - mvs, 0);

    idle(5);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/track_playback_scheduler.md
# track_playback_scheduler

Access controller and per-sample read sequencer for a bank of NUM_TRACKS single-clock track FIFOs (WIDTH-bit samples, edge-triggered rd/wr, DEPTH entries each). The block gates upstream writes against per-track occupancy and, on each audio sample tick, walks the tracks in order. For each track it captures the head sample, advances that FIFO with a single-cycle rd pulse, applies per-track gain and mute, and emits one saturated mixed sample. It sits between the track loaders (writers) and the audio output path.

## Interface
- NUM_TRACKS, 4, number of track FIFOs controlled.
- WIDTH, 16, signed sample width; equals the FIFO WIDTH.
- DEPTH, 512, FIFO depth; equals the FIFO DEPTH.
- GAIN_WIDTH, 8, unsigned gain in Q1.7; 128 is unity.
- clk  in  1  system clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous, active-high; the FIFO bank shares this reset.
- sample_tick  in  1  one-cycle pulse per output sample.
- wr_req  in  NUM_TRACKS  one-cycle write request per track; FIFO din is driven by the requester.
- fifo_wr  out  NUM_TRACKS  combinational: wr_req[k] & ~full[k].
- fifo_rd  out  NUM_TRACKS  one-cycle read-advance pulse to each FIFO.
- fifo_dout  in  NUM_TRACKS*WIDTH  FIFO head samples, packed with track 0 in the LSBs.
- gain  in  NUM_TRACKS*GAIN_WIDTH  per-track gain.
- mute  in  NUM_TRACKS  mutes a track's contribution; reads still occur.
- clear_flags  in  1  clears underrun and overflow.
- level  out  NUM_TRACKS*$clog2(DEPTH)  per-track occupancy.
- full, empty  out  NUM_TRACKS  per-track, derived from level.
- underrun, overflow  out  NUM_TRACKS  sticky flags.
- tick_missed  out  1  sticky flag.
- mix_out  out  WIDTH  signed saturated mix.
- mix_valid  out  1  one-cycle strobe.
- busy  out  1  high whenever state != IDLE.

## Operation
- Occupancy per track:
  - An accepted write is counted on the rising edge of fifo_wr[k]. A held request counts once, matching FIFO edge detection.
  - The read decrement happens in READ.
  - A simultaneous write and read leaves level unchanged.
  - full = (level == DEPTH-1); empty = (level == 0).
- Write to a full track: fifo_wr stays low and overflow[k] sets.
- avail[k] is level[k] with increments delayed 2 cycles, covering FIFO read latency. The scheduler tests only avail.
- FSM states: IDLE, CAPTURE, READ, GAP, DONE. Track index k counts 0..NUM_TRACKS-1.
  - IDLE: sample_tick -> CAPTURE with k=0 and accumulator cleared.
  - CAPTURE: if avail[k]>0, register fifo_dout[k]; its contribution is 0 if mute[k], else (sample*gain)>>>7. If avail[k]==0, contribution is 0, underrun[k] sets and no read follows.
  - CAPTURE -> READ.
  - READ: fifo_rd[k]=1 only if the sample was present; add the contribution to the accumulator.
  - READ -> GAP. GAP keeps fifo_rd low, guaranteeing the low gap the FIFO edge detector needs.
  - GAP: -> CAPTURE with k+1, or -> DONE after the last track.
  - DONE: saturate to WIDTH signed, register mix_out, pulse mix_valid; -> IDLE.
- Arithmetic:
  - Product is WIDTH+GAIN_WIDTH+1 bits signed; the shift is arithmetic.
  - Accumulator is WIDTH+GAIN_WIDTH+$clog2(NUM_TRACKS) bits.
  - Saturation clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- sample_tick while busy is ignored and tick_missed sets.
- gain and mute are sampled in CAPTURE.
- clear_flags clears all sticky flags. A flag event in the same cycle wins, so the flag stays set.

## Timing
- Reset values:
  - state IDLE; level and avail 0; empty all 1; full 0.
  - All flags 0; fifo_rd 0; mix_out 0; mix_valid 0; busy 0.
- Reset mid-sequence aborts the sequence with no mix_valid. The FIFO pointers reset with the same rst, so the counts stay consistent.
- Tick at cycle t: CAPTURE for track 0 at t+1. mix_valid is high at cycle t+2+3*NUM_TRACKS, which is t+14 at the defaults.
- fifo_rd pulses are exactly 1 cycle wide, at most one per track per tick.
- fifo_wr has zero latency relative to wr_req.

## Structure
- Package track_sched_pkg holds:
  - the state_t enum;
  - GAIN_FRAC=7 and GAIN_UNITY=128;
  - a saturate function.
- Sub-module track_level_counter, instantiated once per track, owns:
  - write edge detection and write gating;
  - level and the avail delay line;
  - full/empty and overflow.
- The FSM, multiply-accumulate and saturation stay in the top module.

## Test plan
- Reset, then write 3 samples (1000, -2000, 300) to track 0 at gain 128 and tick three times -> mix_out = 1000, -2000, 300. fifo_rd[0] pulses 3 times, level returns to 0, and mix_valid lands 14 cycles after each tick.
- Track 1 empty on tick -> contribution 0, underrun[1]=1, no fifo_rd[1] pulse. clear_flags -> underrun[1]=0.
- Four tracks each holding 32767 at gain 255 -> mix_out = 32767. All tracks holding -32768 -> mix_out = -32768.
- Write DEPTH-1 samples to track 2, then one more -> full[2]=1, fifo_wr[2] stays low, overflow[2]=1, level holds 511.
- Write to empty track 3 one cycle before its CAPTURE -> treated as underrun. The sample plays on the next tick.
- sample_tick asserted during busy -> tick_missed=1 and only one mix_valid. rst asserted mid-sequence -> no mix_valid and all outputs return to their reset values.
